// File: rtl/led_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_seq_pkg
// Description : Shared encodings for the LED sequencer: FSM states, chase
//               direction, the highest LED position, and small helpers for
//               one-hot LED decoding and direction reversal.
// Revision    : 1.0 - initial release
// ============================================================================
package led_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [1:0] POS_MAX = 2'd2;

    function automatic logic [2:0] pos_to_led(input logic [1:0] pos);
        return 3'b001 << pos;
    endfunction

    function automatic dir_t flip_dir(input dir_t d);
        return (d == DIR_UP) ? DIR_DOWN : DIR_UP;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debouncer.sv
`default_nettype none
// ============================================================================
// Module      : debouncer
// Description : One pushbutton input path: 2-FF synchroniser, stability
//               counter and press-event generator.
//   clk       in  system clock
//   rst_n     in  asynchronous active-low reset
//   i_btn_n   in  raw button, active-low, asynchronous
//   o_pressed out debounced level, 1 = button held down
//   o_press   out one-cycle pulse on each debounced press
// Revision    : 1.0 - initial release
// ============================================================================
module debouncer #(
    parameter int DEBOUNCE_CYCLES = 120_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn_n,
    output logic o_pressed,
    output logic o_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_state;   // debounced level, active-low like the pin
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_btn_n;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 != r_state) begin
                // This cycle is the DEBOUNCE_CYCLES-th consecutive mismatch.
                if (r_cnt == CNT_MAX) begin
                    r_state <= r_sync2;
                    r_cnt   <= '0;
                    r_press <= ~r_sync2;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_pressed = ~r_state;
    assign o_press   = r_press;

endmodule
`default_nettype wire

// File: rtl/led_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : led_sequencer
// Description : Runs a one-hot chaser on three LEDs, controlled by two
//               debounced active-low pushbuttons. btn0 starts/pauses/resumes,
//               btn1 reverses direction, both together stop.
//   clk      in  system clock
//   rst_btn  in  asynchronous active-low reset
//   pmod     in  [1:0] raw pushbuttons, active-low
//   led      out [2:0] LED drive, active-high, registered
// Config      : LED_SEQ_PINGPONG_EN - bounce at the ends instead of wrapping
// Revision    : 1.0 - initial release
// ============================================================================
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 120_000,
    parameter int STEP_CYCLES     = 3_000_000
) (
    input  logic       clk,
    input  logic       rst_btn,
    input  logic [1:0] pmod,
    output logic [2:0] led
);

    localparam int TIMER_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(STEP_CYCLES - 1);

    logic [1:0] w_btn_pressed;
    logic [1:0] w_btn_press;

    for (genvar i = 0; i < 2; i++) begin : g_btn
        debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clk      (clk),
            .rst_n    (rst_btn),
            .i_btn_n  (pmod[i]),
            .o_pressed(w_btn_pressed[i]),
            .o_press  (w_btn_press[i])
        );
    end

    state_t             r_state;
    dir_t               r_dir;
    logic [1:0]         r_pos;
    logic [TIMER_W-1:0] r_timer;
    logic [2:0]         r_led;

    logic       w_chord;
    logic       w_terminal;
    logic [1:0] w_step_pos;
    dir_t       w_step_dir;

    // A press while the other button is already held (which includes both
    // presses landing in the same cycle) is a stop request.
    assign w_chord = (w_btn_press[0] & w_btn_pressed[1]) |
                     (w_btn_press[1] & w_btn_pressed[0]);

    assign w_terminal = (r_timer == TIMER_MAX);

    always_comb begin
        w_step_pos = r_pos;
        w_step_dir = r_dir;
`ifdef LED_SEQ_PINGPONG_EN
        if (r_dir == DIR_UP) begin
            if (r_pos == POS_MAX) begin
                w_step_dir = DIR_DOWN;
                w_step_pos = POS_MAX - 2'd1;
            end else begin
                w_step_pos = r_pos + 2'd1;
            end
        end else begin
            if (r_pos == 2'd0) begin
                w_step_dir = DIR_UP;
                w_step_pos = 2'd1;
            end else begin
                w_step_pos = r_pos - 2'd1;
            end
        end
`else
        if (r_dir == DIR_UP) begin
            w_step_pos = (r_pos == POS_MAX) ? 2'd0 : r_pos + 2'd1;
        end else begin
            w_step_pos = (r_pos == 2'd0) ? POS_MAX : r_pos - 2'd1;
        end
`endif
    end

    // led is updated on the same edge as the state/pos it reflects.
    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            r_state <= ST_IDLE;
            r_dir   <= DIR_UP;
            r_pos   <= 2'd0;
            r_timer <= '0;
            r_led   <= 3'b000;
        end else if (w_chord) begin
            r_state <= ST_IDLE;
            r_pos   <= 2'd0;
            r_timer <= '0;
            r_led   <= 3'b000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_btn_press[0]) begin
                        r_state <= ST_RUN;
                        r_pos   <= 2'd0;
                        r_timer <= '0;
                        r_led   <= pos_to_led(2'd0);
                    end
                    if (w_btn_press[1]) begin
                        r_dir <= flip_dir(r_dir);
                    end
                end
                ST_RUN: begin
                    if (w_btn_press[0]) begin
                        r_state <= ST_PAUSE;
                    end else if (w_terminal) begin
                        // Step uses the current direction; a simultaneous
                        // btn1 reversal applies from the following step.
                        r_timer <= '0;
                        r_pos   <= w_step_pos;
                        r_led   <= pos_to_led(w_step_pos);
                        r_dir   <= w_btn_press[1] ? flip_dir(w_step_dir) : w_step_dir;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                        if (w_btn_press[1]) begin
                            r_dir <= flip_dir(r_dir);
                        end
                    end
                end
                ST_PAUSE: begin
                    if (w_btn_press[0]) begin
                        r_state <= ST_RUN;
                    end
                    if (w_btn_press[1]) begin
                        r_dir <= flip_dir(r_dir);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_pos   <= 2'd0;
                    r_timer <= '0;
                    r_led   <= 3'b000;
                end
            endcase
        end
    end

    assign led = r_led;

endmodule
`default_nettype wire

// File: tb/tb_led_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_sequencer
// Description : Self-checking bench for led_sequencer (DEBOUNCE_CYCLES=4,
//               STEP_CYCLES=8). Directed scenarios followed by random button
//               activity, compared every cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_sequencer;

    localparam int DEB  = 4;
    localparam int STEP = 8;

    logic       clk;
    logic       rst_btn;
    logic [1:0] pmod;
    logic [2:0] led;

    int checks;
    int errors;

    led_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .STEP_CYCLES    (STEP)
    ) dut (
        .clk    (clk),
        .rst_btn(rst_btn),
        .pmod   (pmod),
        .led    (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_s1    [2];   // pin sample from the last edge
    int m_s2    [2];   // pin sample from two edges ago
    int m_deb   [2];   // debounced pin level (1 = released)
    int m_run   [2];   // consecutive edges the sample disagreed with m_deb
    int m_press [2];   // press seen by the controller at the next edge
    int m_mode;        // 0 idle, 1 running, 2 paused
    int m_pos;
    int m_dir;         // +1 up, -1 down
    int m_timer;

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_s1[b] = 1; m_s2[b] = 1; m_deb[b] = 1; m_run[b] = 0; m_press[b] = 0;
        end
        m_mode = 0; m_pos = 0; m_dir = 1; m_timer = 0;
    endtask

    task automatic model_step_pos();
`ifdef LED_SEQ_PINGPONG_EN
        if (m_pos + m_dir > 2 || m_pos + m_dir < 0) m_dir = -m_dir;
        m_pos = m_pos + m_dir;
`else
        m_pos = (m_pos + m_dir + 3) % 3;
`endif
    endtask

    task automatic model_edge();
        int p0, p1, h0, h1;
        int np [2];
        p0 = m_press[0]; p1 = m_press[1];
        h0 = (m_deb[0] == 0); h1 = (m_deb[1] == 0);
        if ((p0 && h1) || (p1 && h0)) begin
            m_mode = 0; m_pos = 0; m_timer = 0;
        end else if (m_mode == 0) begin
            if (p0) begin m_mode = 1; m_pos = 0; m_timer = 0; end
            if (p1) m_dir = -m_dir;
        end else if (m_mode == 1) begin
            if (p0) m_mode = 2;
            else begin
                if (m_timer == STEP - 1) begin
                    m_timer = 0;
                    model_step_pos();
                end else m_timer++;
                if (p1) m_dir = -m_dir;
            end
        end else begin
            if (p0) m_mode = 1;
            if (p1) m_dir = -m_dir;
        end
        for (int b = 0; b < 2; b++) begin
            np[b] = 0;
            if (m_s2[b] != m_deb[b]) begin
                m_run[b]++;
                if (m_run[b] == DEB) begin
                    m_deb[b] = m_s2[b];
                    m_run[b] = 0;
                    np[b] = (m_deb[b] == 0);
                end
            end else m_run[b] = 0;
            m_press[b] = np[b];
            m_s2[b] = m_s1[b];
            m_s1[b] = int'(pmod[b]);
        end
    endtask

    function automatic logic [2:0] model_led();
        logic [2:0] one;
        one = 3'b001;
        return (m_mode == 0) ? 3'b000 : (one << m_pos);
    endfunction

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_btn) model_edge();
        else model_reset();
        #1;
        check_eq("led_model", 32'(led), 32'(model_led()));
    endtask

    task automatic hold_reset(input int cycles);
        pmod    = 2'b11;
        rst_btn = 1'b0;
        model_reset();
        #1;
        check_eq("reset_async", 32'(led), 32'h0);
        repeat (cycles) tick();
        rst_btn = 1'b1;
    endtask

    logic [2:0] c_wrap [0:3];

    initial begin
        checks = 0;
        errors = 0;
        rst_btn = 1'b0;
        pmod = 2'b11;
        model_reset();
`ifdef LED_SEQ_PINGPONG_EN
        c_wrap = '{3'b001, 3'b010, 3'b100, 3'b010};
`else
        c_wrap = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif
        repeat (3) tick();
        check_eq("reset_led", 32'(led), 32'h0);
        rst_btn = 1'b1;
        repeat (10) tick();
        check_eq("idle_led", 32'(led), 32'h0);

        // Short glitch must be ignored.
        pmod[0] = 1'b0;
        repeat (3) tick();
        pmod[0] = 1'b1;
        repeat (12) tick();
        check_eq("glitch", 32'(led), 32'h0);

        // Real press: led lights exactly 7 edges after the pin edge.
        pmod[0] = 1'b0;
        repeat (6) tick();
        check_eq("deb_early", 32'(led), 32'h0);
        tick();
        check_eq("deb_edge", 32'(led), 32'(c_wrap[0]));
        pmod[0] = 1'b1;
        for (int k = 1; k < 4; k++) begin
            repeat (STEP) tick();
            check_eq("wrap", 32'(led), 32'(c_wrap[k]));
        end

        // Pause with led=010, timer=5.
`ifdef LED_SEQ_PINGPONG_EN
        repeat (15) tick();
`else
        repeat (7) tick();
`endif
        pmod[0] = 1'b0;
        repeat (5) tick();
        pmod[0] = 1'b1;
        repeat (2) tick();
        check_eq("pause_led", 32'(led), 32'h2);
        repeat (20) tick();
        check_eq("pause_hold", 32'(led), 32'h2);
        pmod[0] = 1'b0;
        repeat (5) tick();
        pmod[0] = 1'b1;
        repeat (2) tick();
        check_eq("resume_led", 32'(led), 32'h2);
        repeat (2) tick();
        check_eq("resume_wait", 32'(led), 32'h2);
        tick();
        check_eq("resume_step", 32'(led), 32'h4);

        // Direction reversal while at 010.
        repeat (10) tick();
        pmod[1] = 1'b0;
        repeat (5) tick();
        pmod[1] = 1'b1;
        repeat (9) tick();
`ifndef LED_SEQ_PINGPONG_EN
        check_eq("dir_first", 32'(led), 32'h1);
`endif
        repeat (STEP) tick();
`ifndef LED_SEQ_PINGPONG_EN
        check_eq("dir_second", 32'(led), 32'h4);
`endif

        // Chord: btn1 held, then btn0 pressed.
        pmod[1] = 1'b0;
        repeat (10) tick();
        pmod[0] = 1'b0;
        repeat (7) tick();
        check_eq("chord_stop", 32'(led), 32'h0);
        pmod = 2'b11;
        repeat (15) tick();
        check_eq("chord_idle", 32'(led), 32'h0);
        pmod[0] = 1'b0;
        repeat (5) tick();
        pmod[0] = 1'b1;
        tick();
        check_eq("chord_pre", 32'(led), 32'h0);
        tick();
        check_eq("chord_restart", 32'(led), 32'h1);

        // Asynchronous reset in the middle of RUN.
        repeat (5) tick();
        hold_reset(3);
        repeat (20) tick();
        check_eq("reset_idle", 32'(led), 32'h0);

        // Random button activity.
        for (int it = 0; it < 250; it++) begin
            int act;
            int dur;
            act = int'($urandom_range(0, 9));
            dur = int'($urandom_range(1, 12));
            case (act)
                0, 1, 2, 3: begin
                    pmod[0] = 1'b0;
                    repeat (dur) tick();
                end
                4, 5, 6: begin
                    pmod[1] = 1'b0;
                    repeat (dur) tick();
                end
                7: begin
                    pmod = 2'b00;
                    repeat (dur) tick();
                end
                8: begin
                    pmod[1] = 1'b0;
                    repeat (dur) tick();
                    pmod[0] = 1'b0;
                    repeat (int'($urandom_range(1, 10))) tick();
                end
                default: begin
                    if ($urandom_range(0, 3) == 0) hold_reset(int'($urandom_range(1, 3)));
                    else repeat (int'($urandom_range(1, 30))) tick();
                end
            endcase
            pmod = 2'b11;
            repeat (int'($urandom_range(0, 12))) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
